sclk_burst_gen: RTL and testbench
=================================

// Module: sclk_burst_gen
// PURPOSE
// - Generates a gated serial clock SCLK: a burst of NPULSE pulses at a programmable rate.
// - Sits directly upstream of the SCLK falling-edge counter in the noisy-image path.
// - The downstream counter samples SCLK on CLK, so every high and low phase lasts >=1 CLK cycle.
// - Reports burst progress and completion to the controlling sequencer.
// PARAMETERS
// - DIV_W   8  width of DIV (half-period select)
// - NP_W    9  width of NPULSE; the default 9 covers 0..256 pulses, one full 8-bit count wrap
// PORTS
// - CLK     in   1      system clock, rising edge active
// - RST_N   in   1      asynchronous reset, active low
// - START   in   1      burst request; sampled only in IDLE
// - DIV     in   DIV_W  half-period = DIV+1 CLK cycles; latched on accepted START
// - NPULSE  in   NP_W   pulses per burst; latched on accepted START
// - CONT    in   1      continuous mode request; present only with SCLK_CONT_EN
// - SCLK    out  1      generated serial clock, registered, idles low
// - BUSY    out  1      burst in progress
// - DONE    out  1      one-cycle pulse at burst end
// - PCNT    out  NP_W   falling edges emitted in the current burst
// BEHAVIOUR
// - Reset (RST_N=0, async): state=IDLE; SCLK=0, BUSY=0, DONE=0, PCNT=0; phase timer=0.
// - A reset mid-burst aborts the burst immediately. No DONE is produced.
// - FSM states: IDLE, HIGH, LOW, FIN.
//   - IDLE: when START=1 and NPULSE!=0 at edge k: latch DIV and NPULSE, go to HIGH.
//     From cycle k+1: SCLK=1, BUSY=1, PCNT=0.
//   - IDLE: when START=1 and NPULSE=0: go to FIN. No SCLK activity.
//   - HIGH: hold SCLK=1 for DIV+1 cycles, then go to LOW.
//   - LOW: hold SCLK=0 for DIV+1 cycles. PCNT increments in the first LOW cycle (the falling edge).
//   - LOW end: if PCNT==latched NPULSE, go to FIN; otherwise go to HIGH.
//   - FIN: lasts one cycle. DONE=1 and BUSY=0 in this cycle. Next state is IDLE.
// - Timing: BUSY is high in cycles k+1..k+2*N*(DIV+1). DONE is high at cycle k+2*N*(DIV+1)+1.
// - START while BUSY=1 or in FIN is ignored. START is a level; if held, a new burst is accepted in the cycle after FIN.
// - DIV and NPULSE changes mid-burst have no effect; only the latched copies are used.
// - PCNT holds its final value until the next accepted START, which clears it to 0.
// - The phase timer is a DIV_W-bit down-counter loaded with DIV on every phase entry; the phase ends at 0.
// - DIV=0: SCLK toggles every CLK cycle (50% duty, CLK/2).
// - DIV=2^DIV_W-1: each phase lasts 2^DIV_W cycles. No overflow, because the timer only counts down.
// - NPULSE=2^(NP_W-1) (256 by default): PCNT reaches 256. The downstream 8-bit counter wraps exactly once.
// CONFIGURATION
// - Macro SCLK_CONT_EN:
//   - Defined: the CONT port exists. If CONT=1 at the LOW end of the last pulse, PCNT reloads to 0.
//     The FSM returns to HIGH, skips FIN and gives no DONE; SCLK continues gap-free.
//     BUSY stays high until a burst ends with CONT=0.
//   - Undefined: no CONT port. Every burst terminates via FIN as described above.
// STRUCTURE
// - Shared package noise_pkg holds:
//   - sclk_state_t enum {IDLE, HIGH, LOW, FIN};
//   - DIV_W_DEF=8, NP_W_DEF=9.
// - One sub-module, sclk_phase_timer (load/decrement/zero flag, DIV_W wide).
//   It is instantiated once by this FSM.
// TESTING
// - DIV=0, NPULSE=4, START pulse at edge k -> SCLK 1,0,1,0,1,0,1,0 in cycles k+1..k+8.
//   DONE at k+9; PCNT=4.
// - DIV=2, NPULSE=1 -> SCLK high in cycles k+1..k+3, low in k+4..k+6; DONE at k+7; PCNT=1.
// - NPULSE=0 -> DONE at k+1, BUSY never 1, SCLK stays 0.
// - START re-pulsed during a burst and DIV changed mid-burst -> no effect on timing or pulse count.
// - RST_N low at cycle k+3 of a DIV=0, NPULSE=4 burst -> SCLK, BUSY and PCNT all 0 at once; no DONE.
//   A later START runs a full burst.
// - SCLK_CONT_EN defined, CONT=1, DIV=0, NPULSE=2 -> SCLK toggles without gaps and DONE stays 0.
//   Dropping CONT -> DONE one cycle after the current burst ends.

Source files
------------

// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared types and defaults for the noisy-image SCLK path
// Purpose: FSM state type and default widths used by sclk_burst_gen and its interface.
// Ports: none (package).
// Optional feature macro: SCLK_CONT_EN (used by sclk_burst_gen and sclk_burst_gen_if).
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } sclk_state_t;

  localparam int DIV_W_DEF = 8;
  localparam int NP_W_DEF  = 9;

endpackage

// File: rtl/sclk_burst_gen_if.sv
// rtl/sclk_burst_gen_if.sv - request/status bundle between sequencer and SCLK burst generator
// Purpose: groups burst request inputs and SCLK/status outputs.
// Signals: START, DIV, NPULSE, CONT (only with SCLK_CONT_EN) driven by the master;
//          SCLK, BUSY, DONE, PCNT driven by the slave (sclk_burst_gen).
// Modports: master (sequencer side), slave (generator side).
// Optional feature macro: SCLK_CONT_EN adds the CONT signal.
interface sclk_burst_gen_if #(
  parameter int DIV_W = noise_pkg::DIV_W_DEF,
  parameter int NP_W  = noise_pkg::NP_W_DEF
);

  logic             START;
  logic [DIV_W-1:0] DIV;
  logic [NP_W-1:0]  NPULSE;
`ifdef SCLK_CONT_EN
  logic             CONT;
`endif
  logic             SCLK;
  logic             BUSY;
  logic             DONE;
  logic [NP_W-1:0]  PCNT;

  modport master (
    output START, DIV, NPULSE,
`ifdef SCLK_CONT_EN
    output CONT,
`endif
    input  SCLK, BUSY, DONE, PCNT
  );

  modport slave (
    input  START, DIV, NPULSE,
`ifdef SCLK_CONT_EN
    input  CONT,
`endif
    output SCLK, BUSY, DONE, PCNT
  );

endinterface

// File: rtl/sclk_phase_timer.sv
// rtl/sclk_phase_timer.sv - loadable down-counter timing one SCLK phase
// Purpose: counts a phase of load_val+1 cycles; zero flags the last cycle of the phase.
// Ports: clk, rst_n (async, active low), load, load_val[DIV_W], dec -> zero.
module sclk_phase_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // Counting only downward means the largest DIV never overflows.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sclk_burst_gen.sv
// rtl/sclk_burst_gen.sv - gated SCLK burst generator with programmable half-period
// Purpose: on START emits NPULSE SCLK pulses, each phase DIV+1 CLK cycles long,
//          reports BUSY, a one-cycle DONE at burst end and the falling-edge count PCNT.
// Ports: CLK, RST_N (async, active low); bus (sclk_burst_gen_if.slave):
//        START, DIV, NPULSE, CONT (SCLK_CONT_EN only) in; SCLK, BUSY, DONE, PCNT out.
// Optional feature macro: SCLK_CONT_EN enables continuous mode via CONT.
module sclk_burst_gen
  import noise_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int NP_W  = NP_W_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  sclk_burst_gen_if.slave    bus
);

  sclk_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [NP_W-1:0]  np_q, np_d;
  logic [NP_W-1:0]  pcnt_q, pcnt_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [DIV_W-1:0] tmr_val;
  logic             cont_req;

`ifdef SCLK_CONT_EN
  assign cont_req = bus.CONT;
`else
  assign cont_req = 1'b0;
`endif

  // In IDLE the latched copy is not valid yet, so the first phase loads DIV directly.
  assign tmr_val = (state_q == IDLE) ? bus.DIV : div_q;

  sclk_phase_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    np_d     = np_q;
    pcnt_d   = pcnt_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          div_d  = bus.DIV;
          np_d   = bus.NPULSE;
          pcnt_d = '0;
          if (bus.NPULSE != '0) begin
            state_d  = HIGH;
            tmr_load = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          // Entering LOW is the falling edge, so the count moves with it.
          state_d  = LOW;
          tmr_load = 1'b1;
          pcnt_d   = pcnt_q + NP_W'(1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      LOW: begin
        if (tmr_zero) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          if (pcnt_q == np_q) begin
            if (cont_req) begin
              pcnt_d = '0;
            end else begin
              state_d  = FIN;
              tmr_load = 1'b0;
            end
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    sclk_d = (state_d == HIGH);
    busy_d = (state_d == HIGH) || (state_d == LOW);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      np_q    <= '0;
      pcnt_q  <= '0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      np_q    <= np_d;
      pcnt_q  <= pcnt_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SCLK = sclk_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.PCNT = pcnt_q;

endmodule

// File: tb/tb_sclk_burst_gen.sv
// tb/tb_sclk_burst_gen.sv - scoreboard bench for sclk_burst_gen
// Stimulus pushes per-cycle expected SCLK/BUSY/DONE/PCNT into a queue; a negedge monitor compares.
// Optional feature macro: SCLK_CONT_EN enables the continuous-mode scenario.
module tb_sclk_burst_gen;

  localparam int DW = 8;
  localparam int NW = 9;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  sclk_burst_gen_if #(.DIV_W(DW), .NP_W(NW)) bif ();

  sclk_burst_gen #(.DIV_W(DW), .NP_W(NW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bif)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            cyc;
    logic          sclk;
    logic          busy;
    logic          done;
    logic [NW-1:0] pcnt;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;
  bit   mon_had;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void push(input int c, input logic s, input logic b, input logic d, input int p);
    exp_t e;
    e.cyc = c; e.sclk = s; e.busy = b; e.done = d; e.pcnt = NW'(p);
    expq.push_back(e);
  endfunction

  // Expected trace of a burst whose first active cycle is sample index b.
  function automatic void model_burst(input int b, input int d, input int n, input int idle);
    int len;
    int ph;
    len = 2 * n * (d + 1);
    for (int j = 1; j <= len; j++) begin
      ph = (j - 1) / (d + 1);
      push(b + j - 1, (ph % 2) == 0, 1'b1, 1'b0, (ph + 1) / 2);
    end
    push(b + len, 1'b0, 1'b0, 1'b1, n);
    for (int i = 1; i <= idle; i++) push(b + len + i, 1'b0, 1'b0, 1'b0, n);
  endfunction

  // Monitor: compare the DUT against the scoreboard entry for this sample, if any.
  always @(negedge CLK) begin
    mon_had = 1'b0;
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missed_sample expected cycle %0d not observed (now %0d)", expq[0].cyc, cyc);
      void'(expq.pop_front());
    end
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      mon_e = expq.pop_front();
      mon_had = 1'b1;
      checks++;
      if ({bif.SCLK, bif.BUSY, bif.DONE, bif.PCNT} !== {mon_e.sclk, mon_e.busy, mon_e.done, mon_e.pcnt}) begin
        errors++;
        $display("FAIL outputs cyc=%0d got sclk=%b busy=%b done=%b pcnt=%0d want sclk=%b busy=%b done=%b pcnt=%0d",
                 cyc, bif.SCLK, bif.BUSY, bif.DONE, bif.PCNT, mon_e.sclk, mon_e.busy, mon_e.done, mon_e.pcnt);
      end
    end
    if (!mon_had) begin
      checks++;
      if (bif.DONE !== 1'b0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d got done=%b want 0", cyc, bif.DONE);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 3000) begin
      @(posedge CLK);
      n++;
    end
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending entries want 0", expq.size());
      expq.delete();
    end
  endtask

  // Issues a one-cycle START and schedules its expectations before the DUT can react.
  task automatic run_burst(input int d, input int n, input int idle, output int b);
    @(negedge CLK);
    bif.DIV = DW'(d); bif.NPULSE = NW'(n); bif.START = 1'b1;
    b = cyc + 1;
    model_burst(b, d, n, idle);
    @(negedge CLK);
    bif.START = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1_s;
  int         t1_p[8];

  initial begin
    int b;
    int b2;
    int guard;
    bif.START = 1'b0; bif.DIV = '0; bif.NPULSE = '0;
`ifdef SCLK_CONT_EN
    bif.CONT = 1'b0;
`endif
    // Reset state.
    push(1, 1'b0, 1'b0, 1'b0, 0);
    push(2, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // DIV=0, NPULSE=4: hand-written trace.
    t1_s = 8'b1010_1010;
    t1_p = '{0, 1, 1, 2, 2, 3, 3, 4};
    @(negedge CLK);
    bif.DIV = 8'd0; bif.NPULSE = 9'd4; bif.START = 1'b1;
    b = cyc + 1;
    for (int j = 0; j < 8; j++) push(b + j, t1_s[7-j], 1'b1, 1'b0, t1_p[j]);
    push(b + 8, 1'b0, 1'b0, 1'b1, 4);
    push(b + 9, 1'b0, 1'b0, 1'b0, 4);
    @(negedge CLK);
    bif.START = 1'b0;
    drain();

    // DIV=2, NPULSE=1.
    run_burst(2, 1, 2, b);
    drain();

    // NPULSE=0: immediate DONE, no SCLK, PCNT cleared.
    run_burst(5, 0, 3, b);
    drain();

    // START re-pulsed and DIV/NPULSE changed mid-burst.
    run_burst(3, 3, 2, b);
    repeat (2) @(negedge CLK);
    bif.DIV = 8'd7; bif.NPULSE = 9'd1; bif.START = 1'b1;
    @(negedge CLK);
    bif.START = 1'b0;
    repeat (8) @(negedge CLK);
    bif.START = 1'b1;
    @(negedge CLK);
    bif.START = 1'b0;
    drain();

    // Reset asserted in cycle k+3 of a DIV=0, NPULSE=4 burst.
    @(negedge CLK);
    bif.DIV = 8'd0; bif.NPULSE = 9'd4; bif.START = 1'b1;
    b = cyc + 1;
    push(b, 1'b1, 1'b1, 1'b0, 0);
    push(b + 1, 1'b0, 1'b1, 1'b0, 1);
    for (int i = 2; i < 8; i++) push(b + i, 1'b0, 1'b0, 1'b0, 0);
    @(negedge CLK);
    bif.START = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    drain();
    run_burst(0, 4, 1, b);
    drain();

    // START held: second burst accepted the cycle after FIN.
    @(negedge CLK);
    bif.DIV = 8'd0; bif.NPULSE = 9'd1; bif.START = 1'b1;
    b = cyc + 1;
    b2 = b + 4;
    model_burst(b, 0, 1, 1);
    model_burst(b2, 0, 2, 2);
    @(negedge CLK);
    bif.NPULSE = 9'd2;
    guard = 0;
    while (cyc != b2 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    bif.START = 1'b0;
    drain();

    // Boundaries: 256 pulses, and the longest phase.
    run_burst(0, 256, 1, b);
    drain();
    run_burst(255, 1, 1, b);
    drain();

`ifdef SCLK_CONT_EN
    // Continuous mode: three gap-free passes of 2 pulses, then FIN after CONT drops.
    @(negedge CLK);
    bif.DIV = 8'd0; bif.NPULSE = 9'd2; bif.START = 1'b1; bif.CONT = 1'b1;
    b = cyc + 1;
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 4; j++) push(b + 4 * p + j, (j % 2) == 0, 1'b1, 1'b0, (j + 1) / 2);
    push(b + 12, 1'b0, 1'b0, 1'b1, 2);
    push(b + 13, 1'b0, 1'b0, 1'b0, 2);
    @(negedge CLK);
    bif.START = 1'b0;
    guard = 0;
    while (cyc != b + 8 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    bif.CONT = 1'b0;
    drain();
`endif

    repeat (2) @(negedge CLK);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_empty got %0d entries want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
